// File: rtl/ft6206_responder.sv
// ---------------------------------------------------------------------------
// ft6206_responder
//   I2C target emulating the FT6206 capacitive-touch controller. SCL/SDA are
//   oversampled on clk (clk must be >= 20x the SCL rate) and SDA is driven
//   open-drain through sda_oe.
//
//   Optional feature: define FT6206_RESPONDER_IRQ_EN to add the active-low
//   touch_irq output. Without it the port does not exist.
//
// Ports
//   clk           system clock
//   rst           asynchronous active-low reset
//   scl, sda_i    I2C bus as seen by this target
//   sda_oe        1 = pull SDA low, 0 = release
//   touchN_*      live touch points (valid + COORD_W-bit x/y)
//   th_group      threshold register 0x80, writable over I2C
//   busy          high from an address match until STOP or read NACK
//   touch_irq     (FT6206_RESPONDER_IRQ_EN only) active-low touch interrupt
//   dbg_state     current FSM state encoding
//
// Bus handshake: every bit is sampled on a synchronized SCL rising edge and
// sda_oe only changes on the clk cycle after a synchronized SCL falling edge,
// so SDA is always stable while SCL is high. START/STOP override everything.
// ---------------------------------------------------------------------------
module ft6206_responder #(
    parameter logic [6:0] I2C_ADDR  = 7'h38,
    parameter int         COORD_W   = 9,
    parameter logic [7:0] CHIP_ID   = 8'h06,
    parameter logic [7:0] VENDOR_ID = 8'h11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scl,
    input  logic               sda_i,
    output logic               sda_oe,
    input  logic               touch0_valid,
    input  logic [COORD_W-1:0] touch0_x,
    input  logic [COORD_W-1:0] touch0_y,
    input  logic               touch1_valid,
    input  logic [COORD_W-1:0] touch1_x,
    input  logic [COORD_W-1:0] touch1_y,
    output logic [7:0]         th_group,
    output logic               busy,
`ifdef FT6206_RESPONDER_IRQ_EN
    output logic               touch_irq,
`endif
    output logic [3:0]         dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR     = 4'd1,
        S_ADDR_ACK = 4'd2,
        S_PTR      = 4'd3,
        S_PTR_ACK  = 4'd4,
        S_WR       = 4'd5,
        S_WR_ACK   = 4'd6,
        S_RD       = 4'd7,
        S_RD_ACK   = 4'd8,
        S_IGNORE   = 4'd9
    } state_t;

    // Synchronizers: s1/s2 are the two sync flops, d is the previous value
    // used for edge detection. Reset to 1 to match an idle bus.
    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    state_t       r_state;
    logic [2:0]   r_bit_cnt;
    logic [7:0]   r_shift;
    // In *_ACK states that we drive: "ACK already driven". In S_RD_ACK:
    // "initiator ACKed, load next byte on the coming fall".
    logic         r_ack_flag;
    logic         r_rw;
    logic [7:0]   r_ptr;
    logic         r_sda_oe;
    logic [7:0]   r_th;
    logic         r_busy;

    // Snapshot taken when a read address is accepted so bursts are coherent.
    logic               r_snap_v0, r_snap_v1;
    logic [COORD_W-1:0] r_snap_x0, r_snap_y0, r_snap_x1, r_snap_y1;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_rx_byte;
    logic [7:0] w_rd_byte;
    logic [11:0] w_x0, w_y0, w_x1, w_y1;
    logic [1:0] w_td;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

    // Byte as it stands once the bit being sampled now is shifted in.
    assign w_rx_byte = {r_shift[6:0], r_sda_s2};

    assign w_x0 = 12'(r_snap_x0);
    assign w_y0 = 12'(r_snap_y0);
    assign w_x1 = 12'(r_snap_x1);
    assign w_y1 = 12'(r_snap_y1);
    assign w_td = {1'b0, r_snap_v0} + {1'b0, r_snap_v1};

    // Register map, served from the snapshot.
    always_comb begin
        w_rd_byte = 8'h00;
        case (r_ptr)
            8'h02: w_rd_byte = {6'd0, w_td};
            8'h03: w_rd_byte = {(r_snap_v0 ? 2'b10 : 2'b11), 2'b00, w_x0[11:8]};
            8'h04: w_rd_byte = w_x0[7:0];
            8'h05: w_rd_byte = {4'h0, w_y0[11:8]};
            8'h06: w_rd_byte = w_y0[7:0];
            8'h09: w_rd_byte = {(r_snap_v1 ? 2'b10 : 2'b11), 2'b00, w_x1[11:8]};
            8'h0A: w_rd_byte = w_x1[7:0];
            8'h0B: w_rd_byte = {4'h1, w_y1[11:8]};
            8'h0C: w_rd_byte = w_y1[7:0];
            8'h80: w_rd_byte = r_th;
            8'hA3: w_rd_byte = CHIP_ID;
            8'hA8: w_rd_byte = VENDOR_ID;
            default: w_rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_s1   <= 1'b1;
            r_scl_s2   <= 1'b1;
            r_scl_d    <= 1'b1;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
            r_sda_d    <= 1'b1;
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_ack_flag <= 1'b0;
            r_rw       <= 1'b0;
            r_ptr      <= 8'h00;
            r_sda_oe   <= 1'b0;
            r_th       <= 8'd128;
            r_busy     <= 1'b0;
            r_snap_v0  <= 1'b0;
            r_snap_v1  <= 1'b0;
            r_snap_x0  <= '0;
            r_snap_y0  <= '0;
            r_snap_x1  <= '0;
            r_snap_y1  <= '0;
        end else begin
            r_scl_s1 <= scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;

            if (w_start) begin
                r_state    <= S_ADDR;
                r_bit_cnt  <= 3'd0;
                r_ack_flag <= 1'b0;
                r_sda_oe   <= 1'b0;
            end else if (w_stop) begin
                r_state    <= S_IDLE;
                r_ack_flag <= 1'b0;
                r_sda_oe   <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (w_rx_byte[7:1] == I2C_ADDR) begin
                                    r_state    <= S_ADDR_ACK;
                                    r_rw       <= w_rx_byte[0];
                                    r_ack_flag <= 1'b0;
                                    if (w_rx_byte[0]) begin
                                        r_snap_v0 <= touch0_valid;
                                        r_snap_x0 <= touch0_x;
                                        r_snap_y0 <= touch0_y;
                                        r_snap_v1 <= touch1_valid;
                                        r_snap_x1 <= touch1_x;
                                        r_snap_y1 <= touch1_y;
                                    end
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end
                        end
                    end

                    // First fall drives the ACK, second fall ends it.
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_flag) begin
                                r_sda_oe   <= 1'b1;
                                r_ack_flag <= 1'b1;
                                r_busy     <= 1'b1;
                            end else begin
                                r_ack_flag <= 1'b0;
                                r_bit_cnt  <= 3'd0;
                                if (r_rw) begin
                                    r_state  <= S_RD;
                                    r_shift  <= w_rd_byte;
                                    r_sda_oe <= ~w_rd_byte[7];
                                end else begin
                                    r_state  <= S_PTR;
                                    r_sda_oe <= 1'b0;
                                end
                            end
                        end
                    end

                    S_PTR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_ptr      <= w_rx_byte;
                                r_state    <= S_PTR_ACK;
                                r_ack_flag <= 1'b0;
                            end
                        end
                    end

                    S_PTR_ACK, S_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_flag) begin
                                r_sda_oe   <= 1'b1;
                                r_ack_flag <= 1'b1;
                            end else begin
                                r_sda_oe   <= 1'b0;
                                r_ack_flag <= 1'b0;
                                r_bit_cnt  <= 3'd0;
                                r_state    <= S_WR;
                            end
                        end
                    end

                    // Only the threshold register is writable; other
                    // addresses are ACKed and dropped.
                    S_WR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (r_ptr == 8'h80) begin
                                    r_th <= w_rx_byte;
                                end
                                r_ptr      <= r_ptr + 8'd1;
                                r_state    <= S_WR_ACK;
                                r_ack_flag <= 1'b0;
                            end
                        end
                    end

                    // r_shift[7] is the bit currently on the bus.
                    S_RD: begin
                        if (w_scl_fall) begin
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_sda_oe <= ~r_shift[6];
                        end
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state    <= S_RD_ACK;
                                r_ack_flag <= 1'b0;
                            end
                        end
                    end

                    S_RD_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_flag) begin
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_state    <= S_RD;
                                r_shift    <= w_rd_byte;
                                r_sda_oe   <= ~w_rd_byte[7];
                                r_bit_cnt  <= 3'd0;
                                r_ack_flag <= 1'b0;
                            end
                        end
                        if (w_scl_rise) begin
                            r_ptr <= r_ptr + 8'd1;
                            if (r_sda_s2) begin
                                r_state <= S_IGNORE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_ack_flag <= 1'b1;
                            end
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

    assign sda_oe    = r_sda_oe;
    assign th_group  = r_th;
    assign busy      = r_busy;
    assign dbg_state = r_state;

`ifdef FT6206_RESPONDER_IRQ_EN
    // r_irq_pend keeps the interrupt asserted after the touch goes away
    // until the initiator has read TD_STATUS.
    logic r_irq_pend;
    logic r_touch_irq;
    logic w_any_touch;
    logic w_td_read_done;

    assign w_any_touch    = touch0_valid | touch1_valid;
    assign w_td_read_done = (r_state == S_RD_ACK) && w_scl_rise &&
                            (r_ptr == 8'h02) && !w_start && !w_stop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq_pend  <= 1'b0;
            r_touch_irq <= 1'b1;
        end else begin
            if (w_any_touch) begin
                r_irq_pend <= 1'b1;
            end else if (w_td_read_done) begin
                r_irq_pend <= 1'b0;
            end
            r_touch_irq <= ~(w_any_touch | r_irq_pend);
        end
    end

    assign touch_irq = r_touch_irq;
`endif

endmodule

// File: tb/tb_ft6206_responder.sv
// Bench for ft6206_responder: bit-banged I2C initiator, directed scenarios,
// then randomized touch/threshold/pointer reads compared with a register-map
// model computed from the touch values with plain arithmetic.
module tb_ft6206_responder;

  localparam int QTR = 6;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  logic       sda_line;
  logic       sda_oe;
  logic       t0v, t1v;
  logic [8:0] t0x, t0y, t1x, t1y;
  logic [7:0] th_group;
  logic       busy;
  logic [3:0] dbg_state;
`ifdef FT6206_RESPONDER_IRQ_EN
  logic       touch_irq;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int oe_cnt   = 0;

  // model state
  logic       m_v0, m_v1;
  int         m_x0, m_y0, m_x1, m_y1;
  logic [7:0] m_th;
  logic [7:0] rd_buf [16];
  logic [7:0] exp_q [$];

  assign sda_line = m_sda & ~sda_oe;

  ft6206_responder dut (
    .clk          (clk),
    .rst          (rst),
    .scl          (m_scl),
    .sda_i        (sda_line),
    .sda_oe       (sda_oe),
    .touch0_valid (t0v),
    .touch0_x     (t0x),
    .touch0_y     (t0y),
    .touch1_valid (t1v),
    .touch1_x     (t1x),
    .touch1_y     (t1y),
    .th_group     (th_group),
    .busy         (busy),
`ifdef FT6206_RESPONDER_IRQ_EN
    .touch_irq    (touch_irq),
`endif
    .dbg_state    (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---- bus driver tasks ----
  task automatic q();
    repeat (QTR) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    m_sda = 1'b0; q();
    m_scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; q();
    m_scl = 1'b1; q();
    m_sda = 1'b1; q();
  endtask

  task automatic put_bit(input logic b);
    m_sda = b; q();
    m_scl = 1'b1; q(); q();
    m_scl = 1'b0; q();
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    b = sda_line; q();
    m_scl = 1'b0; q();
  endtask

  task automatic put_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    acked = ~b;
  endtask

  task automatic get_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~ack);
  endtask

  // START, address+W, pointer; leaves the bus mid-transaction.
  task automatic set_ptr(input logic [7:0] p);
    logic a;
    i2c_start();
    put_byte(8'h70, a); chk("ptr_addr_ack", a, 1'b1);
    put_byte(p, a);     chk("ptr_ack", a, 1'b1);
  endtask

  // (repeated) START, address+R, n bytes, NACK on the last, STOP.
  task automatic read_n(input int n);
    logic a;
    i2c_start();
    put_byte(8'h71, a); chk("rd_addr_ack", a, 1'b1);
    for (int i = 0; i < n; i++) get_byte(rd_buf[i], i < n - 1);
    chk("busy_after_nack", busy, 1'b0);
    i2c_stop();
  endtask

  task automatic wr_reg(input logic [7:0] p, input logic [7:0] d);
    logic a;
    set_ptr(p);
    put_byte(d, a); chk("wr_data_ack", a, 1'b1);
    i2c_stop();
  endtask

  // ---- reference model ----
  task automatic snap_model();
    m_v0 = t0v; m_x0 = int'(t0x); m_y0 = int'(t0y);
    m_v1 = t1v; m_x1 = int'(t1x); m_y1 = int'(t1y);
  endtask

  function automatic logic [7:0] model_byte(input logic [7:0] a);
    int r;
    case (a)
      8'h02: r = int'(m_v0) + int'(m_v1);
      8'h03: r = (m_v0 ? 128 : 192) + m_x0 / 256;
      8'h04: r = m_x0 % 256;
      8'h05: r = m_y0 / 256;
      8'h06: r = m_y0 % 256;
      8'h09: r = (m_v1 ? 128 : 192) + m_x1 / 256;
      8'h0A: r = m_x1 % 256;
      8'h0B: r = 16 + m_y1 / 256;
      8'h0C: r = m_y1 % 256;
      8'h80: r = int'(m_th);
      8'hA3: r = 6;
      8'hA8: r = 17;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  // ---- directed + random sequence ----
  initial begin
    logic       a;
    logic [7:0] b;
    logic [7:0] p;
    int         n, oe_before;
    logic [7:0] starts [6];

    starts = '{8'h00, 8'h02, 8'h07, 8'h7E, 8'hA2, 8'hA7};
    rst = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
    t0v = 1'b0; t0x = '0; t0y = '0; t1v = 1'b0; t1x = '0; t1y = '0;
    m_th = 8'd128;
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_th", th_group, 8'd128);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, 4'd0);
`ifdef FT6206_RESPONDER_IRQ_EN
    chk("rst_irq", touch_irq, 1'b1);
`endif
    rst = 1'b1;
    q();

    // 1) six-byte burst from TD_STATUS
    t0v = 1'b1; t0x = 9'd100; t0y = 9'd200;
    set_ptr(8'h02);
    chk("busy_after_match", busy, 1'b1);
    exp_q = '{8'h01, 8'h80, 8'h64, 8'h00, 8'hC8, 8'h00};
    read_n(6);
    for (int i = 0; i < 6; i++) chk("burst6", rd_buf[i], exp_q[i]);
    chk("idle_after_stop", dbg_state, 4'd0);

    // 2) foreign address is never ACKed, then our address works
    oe_before = oe_cnt;
    i2c_start();
    put_byte(8'h72, a); chk("foreign_no_ack", a, 1'b0);
    put_byte(8'h55, a); chk("foreign_data_no_ack", a, 1'b0);
    chk("foreign_oe_never", oe_cnt - oe_before, 0);
    set_ptr(8'hA8);
    snap_model();
    read_n(1);
    chk("vendor_id", rd_buf[0], 8'h11);

    // 3) threshold write; writes elsewhere are dropped
    wr_reg(8'h80, 8'h28);
    m_th = 8'h28;
    chk("th_written", th_group, 8'h28);
    wr_reg(8'hA3, 8'h55);
    chk("th_untouched", th_group, 8'h28);
    set_ptr(8'hA3);
    read_n(1);
    chk("chip_id", rd_buf[0], 8'h06);
    set_ptr(8'h80);
    read_n(1);
    chk("th_readback", rd_buf[0], 8'h28);

    // 4) coordinates change mid-burst: snapshot wins
    set_ptr(8'h04);
    i2c_start();
    put_byte(8'h71, a); chk("snap_addr_ack", a, 1'b1);
    get_byte(rd_buf[0], 1'b1);
    t0x = 9'd50;
    get_byte(rd_buf[1], 1'b1);
    get_byte(rd_buf[2], 1'b0);
    i2c_stop();
    chk("snap_x_lo", rd_buf[0], 8'h64);
    chk("snap_y_hi", rd_buf[1], 8'h00);
    chk("snap_y_lo", rd_buf[2], 8'hC8);
    set_ptr(8'h04);
    read_n(1);
    chk("new_x_lo", rd_buf[0], 8'h32);

    // 5) pointer wraps FF -> 00
    set_ptr(8'hFF);
    snap_model();
    read_n(4);
    for (int i = 0; i < 4; i++) begin
      p = 8'hFF + 8'(i);
      chk("wrap", rd_buf[i], model_byte(p));
    end
    chk("wrap_td", rd_buf[3], 8'h01);

    // 6) reset while the address ACK is on the bus
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      b = 8'h70;
      put_bit(b[i]);
    end
    chk("ack_driven", sda_oe, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_async_oe", sda_oe, 1'b0);
    chk("rst_async_state", dbg_state, 4'd0);
    chk("rst_async_th", th_group, 8'd128);
    m_sda = 1'b1; m_scl = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    m_th = 8'd128;
    q();
    set_ptr(8'h80);
    read_n(1);
    chk("post_rst_th", rd_buf[0], 8'd128);

    // 7) randomized touches, thresholds and burst reads
    for (int it = 0; it < 6; it++) begin
      t0v = 1'($urandom_range(0, 1));
      t1v = 1'($urandom_range(0, 1));
      t0x = 9'($urandom_range(0, 511)); t0y = 9'($urandom_range(0, 511));
      t1x = 9'($urandom_range(0, 511)); t1y = 9'($urandom_range(0, 511));
      b = 8'($urandom_range(0, 255));
      wr_reg(8'h80, b);
      m_th = b;
      chk("rnd_th", th_group, b);
      p = starts[$urandom_range(0, 5)];
      n = $urandom_range(1, 6);
      set_ptr(p);
      snap_model();
      read_n(n);
      for (int k = 0; k < n; k++) chk("rnd_rd", rd_buf[k], model_byte(p + 8'(k)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
